// File: rtl/coffee_boiler_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coffee_boiler_plant: cycle-based boiler/tank plant model driving W, T, P     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module coffee_boiler_plant #(
  parameter int TEMP_W       = 8,
  parameter int TEMP_AMBIENT = 20,
  parameter int TEMP_READY   = 80,
  parameter int TEMP_MAX     = 100,
  parameter int HEAT_DIV     = 4,
  parameter int COOL_DIV     = 16,
  parameter int LEVEL_W      = 8,
  parameter int LEVEL_MIN    = 16,
  parameter int LEVEL_MAX    = 200,
  parameter int DRAIN_DIV    = 2,
  parameter int DRY_LIMIT    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               H,
  input  logic               Brew,
  input  logic               fill,
  input  logic               fault_clr,
  output logic               W,
  output logic               T,
  output logic               P,
  output logic [TEMP_W-1:0]  temp,
  output logic [LEVEL_W-1:0] level
);

  localparam int HEAT_PW  = $clog2(HEAT_DIV + 1);
  localparam int COOL_PW  = $clog2(COOL_DIV + 1);
  localparam int DRAIN_PW = $clog2(DRAIN_DIV + 1);
  localparam int DRY_W    = $clog2(DRY_LIMIT + 1);

  localparam logic [TEMP_W-1:0]   c_temp_ambient = TEMP_W'(TEMP_AMBIENT);
  localparam logic [TEMP_W-1:0]   c_temp_ready   = TEMP_W'(TEMP_READY);
  localparam logic [TEMP_W-1:0]   c_temp_max     = TEMP_W'(TEMP_MAX);
  localparam logic [TEMP_W-1:0]   c_temp_sat     = '1;
  localparam logic [LEVEL_W-1:0]  c_level_min    = LEVEL_W'(LEVEL_MIN);
  localparam logic [LEVEL_W-1:0]  c_level_max    = LEVEL_W'(LEVEL_MAX);
  localparam logic [HEAT_PW-1:0]  c_heat_last    = HEAT_PW'(HEAT_DIV - 1);
  localparam logic [COOL_PW-1:0]  c_cool_last    = COOL_PW'(COOL_DIV - 1);
  localparam logic [DRAIN_PW-1:0] c_drain_last   = DRAIN_PW'(DRAIN_DIV - 1);
  localparam logic [DRY_W-1:0]    c_dry_limit    = DRY_W'(DRY_LIMIT);
  localparam logic [DRY_W-1:0]    c_dry_one      = DRY_W'(1);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DRY_WARN = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  state_t               r_state;
  logic [TEMP_W-1:0]    r_temp;
  logic [LEVEL_W-1:0]   r_level;
  logic [HEAT_PW-1:0]   r_heat_pre;
  logic [COOL_PW-1:0]   r_cool_pre;
  logic [DRAIN_PW-1:0]  r_drain_pre;
  logic [DRY_W-1:0]     r_dry_cnt;
  logic                 r_heat_eff;

  logic                 w_heat_eff;
  logic                 w_mode_chg;
  logic                 w_cooling;
  logic [HEAT_PW-1:0]   w_heat_pre;
  logic [COOL_PW-1:0]   w_cool_pre;
  logic [DRY_W-1:0]     w_dry_next;

  // The edge on which heating-effective toggles counts as the first tick of the new mode.
  always_comb begin
    w_heat_eff = H && (r_state != ST_FAULT);
    w_mode_chg = (w_heat_eff != r_heat_eff);
    w_cooling  = !w_heat_eff && (r_temp > c_temp_ambient);
    w_heat_pre = w_mode_chg ? '0 : r_heat_pre;
    w_cool_pre = w_mode_chg ? '0 : r_cool_pre;
    w_dry_next = r_dry_cnt + c_dry_one;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_temp     <= c_temp_ambient;
      r_heat_pre <= '0;
      r_cool_pre <= '0;
      r_heat_eff <= 1'b0;
    end else begin
      r_heat_eff <= w_heat_eff;
      if (w_heat_eff) begin
        r_cool_pre <= '0;
        if (w_heat_pre == c_heat_last) begin
          r_heat_pre <= '0;
          if (r_temp != c_temp_sat) begin
            r_temp <= r_temp + 1'b1;
          end
        end else begin
          r_heat_pre <= w_heat_pre + 1'b1;
        end
      end else begin
        r_heat_pre <= '0;
        if (w_cooling) begin
          if (w_cool_pre == c_cool_last) begin
            r_cool_pre <= '0;
            r_temp     <= r_temp - 1'b1;
          end else begin
            r_cool_pre <= w_cool_pre + 1'b1;
          end
        end else begin
          r_cool_pre <= '0;
        end
      end
    end
  end

  // Simultaneous fill and brew freezes both the level and the drain phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_level     <= '0;
      r_drain_pre <= '0;
    end else if (fill && !Brew) begin
      r_drain_pre <= '0;
      if (r_level < c_level_max) begin
        r_level <= r_level + 1'b1;
      end
    end else if (Brew && !fill) begin
      if (r_drain_pre == c_drain_last) begin
        r_drain_pre <= '0;
        if (r_level != '0) begin
          r_level <= r_level - 1'b1;
        end
      end else begin
        r_drain_pre <= r_drain_pre + 1'b1;
      end
    end else if (!fill && !Brew) begin
      r_drain_pre <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_NORMAL;
      r_dry_cnt <= '0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (r_temp >= c_temp_max) begin
            r_state <= ST_FAULT;
          end else if (H && (r_level < c_level_min)) begin
            r_state   <= ST_DRY_WARN;
            r_dry_cnt <= c_dry_one;
          end
        end
        ST_DRY_WARN: begin
          if (r_temp >= c_temp_max) begin
            r_state <= ST_FAULT;
          end else if (!H || (r_level >= c_level_min)) begin
            r_state   <= ST_NORMAL;
            r_dry_cnt <= '0;
          end else begin
            r_dry_cnt <= w_dry_next;
            if (w_dry_next >= c_dry_limit) begin
              r_state <= ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr && (r_temp < c_temp_ready)) begin
            r_state   <= ST_NORMAL;
            r_dry_cnt <= '0;
          end
        end
        default: begin
          r_state   <= ST_NORMAL;
          r_dry_cnt <= '0;
        end
      endcase
    end
  end

  assign temp  = r_temp;
  assign level = r_level;
  assign W     = (r_level >= c_level_min);
  assign T     = (r_temp >= c_temp_ready);
  assign P     = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_coffee_boiler_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_coffee_boiler_plant: directed self-checking bench for coffee_boiler_plant |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_coffee_boiler_plant;

  logic       clock;
  logic       reset;
  logic       H;
  logic       Brew;
  logic       fill;
  logic       fault_clr;
  logic       W;
  logic       T;
  logic       P;
  logic [7:0] temp;
  logic [7:0] level;

  int n_tests;
  int n_fail;
  int max_level;

  coffee_boiler_plant dut (
    .clock     (clock),
    .reset     (reset),
    .H         (H),
    .Brew      (Brew),
    .fill      (fill),
    .fault_clr (fault_clr),
    .W         (W),
    .T         (T),
    .P         (P),
    .temp      (temp),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    H = 1'b0; Brew = 1'b0; fill = 1'b0; fault_clr = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_temp(input string tag, input int target, input int bound);
    int k;
    k = 0;
    while ((int'(temp) != target) && (k < bound)) begin
      tick(1);
      k++;
    end
    check(tag, int'(temp), target);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    H = 1'b0; Brew = 1'b0; fill = 1'b0; fault_clr = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_temp", int'(temp), 20);
    check("rst_level", int'(level), 0);
    check("rst_W", int'(W), 0);
    check("rst_T", int'(T), 0);
    check("rst_P", int'(P), 0);
    @(negedge clock);
    reset = 1'b1;

    // fill to threshold then to saturation
    fill = 1'b1;
    tick(15);
    check("fill15_level", int'(level), 15);
    check("fill15_W", int'(W), 0);
    tick(1);
    check("fill16_level", int'(level), 16);
    check("fill16_W", int'(W), 1);
    max_level = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (int'(level) > max_level) max_level = int'(level);
    end
    check("fill_max_seen", max_level, 200);
    check("fill_sat_level", int'(level), 200);
    fill = 1'b0;

    // drain with brew, then hold with fill+brew
    do_reset();
    fill = 1'b1;
    tick(50);
    check("fill50_level", int'(level), 50);
    fill = 1'b0; Brew = 1'b1;
    tick(20);
    check("brew20_level", int'(level), 40);
    fill = 1'b1;
    tick(10);
    check("brew_fill_hold", int'(level), 40);
    fill = 1'b0; Brew = 1'b0;

    // heat to ready point, then cool one step
    H = 1'b1;
    tick(239);
    check("heat239_temp", int'(temp), 79);
    check("heat239_T", int'(T), 0);
    tick(1);
    check("heat240_temp", int'(temp), 80);
    check("heat240_T", int'(T), 1);
    H = 1'b0;
    tick(15);
    check("cool15_temp", int'(temp), 80);
    tick(1);
    check("cool16_temp", int'(temp), 79);
    check("cool16_T", int'(T), 0);

    // over-temperature fault and clear rules
    H = 1'b1;
    wait_temp("heat_to_max", 100, 200);
    tick(1);
    check("otp_P", int'(P), 1);
    check("otp_temp", int'(temp), 100);
    H = 1'b0;
    wait_temp("cool_to_85", 85, 400);
    check("otp85_P", int'(P), 1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("clr_hot_ignored", int'(P), 1);
    wait_temp("cool_to_79", 79, 200);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("clr_cool_P", int'(P), 0);

    // dry heating fault
    do_reset();
    Brew = 1'b1;
    tick(4);
    check("brew_empty_level", int'(level), 0);
    check("brew_empty_P", int'(P), 0);
    Brew = 1'b0;
    H = 1'b1;
    tick(7);
    check("dry7_P", int'(P), 0);
    tick(1);
    check("dry8_P", int'(P), 1);
    H = 1'b0; fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("dry_clr_P", int'(P), 0);

    // asynchronous reset in the middle of heating
    do_reset();
    fill = 1'b1;
    tick(20);
    fill = 1'b0; H = 1'b1;
    tick(160);
    check("mid_temp60", int'(temp), 60);
    check("mid_P", int'(P), 0);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("async_temp", int'(temp), 20);
    check("async_level", int'(level), 0);
    check("async_W", int'(W), 0);
    check("async_T", int'(T), 0);
    check("async_P", int'(P), 0);
    reset = 1'b1;
    H = 1'b0;
    tick(1);
    check("post_rst_temp", int'(temp), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
